// File: rtl/switch_driver_pkg.sv
// switch_driver_pkg: shared constants for the DIP-switch driver.
//   DEBOUNCE_CYCLES_DEF : default number of equal synchronized samples before commit
//   SW_VALUE / SW_CTRL  : register word offsets selected by Addr
//   PENDING / IEN       : bit positions in the control/status word
//   SW_RESET            : reset value of every switch-side register (all pins released)
package switch_driver_pkg;
    localparam int DEBOUNCE_CYCLES_DEF = 20000;
    localparam logic SW_VALUE = 1'b0;
    localparam logic SW_CTRL = 1'b1;
    localparam int PENDING = 0;
    localparam int IEN = 1;
    typedef logic [31:0] sw_word_t;
    localparam sw_word_t SW_RESET = 32'hFFFF_FFFF;
endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer: 2-flop synchronizer plus whole-word debounce counter.
//   clk            : system clock
//   reset          : asynchronous active-low reset
//   raw            : raw active-low switch pins, asynchronous to clk
//   stable         : last committed (debounced) pin word
//   commit_changed : high in the cycle a commit will change stable
module switch_debouncer
    import switch_driver_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset,
    input  sw_word_t raw,
    output sw_word_t stable,
    output logic     commit_changed
);
    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    sw_word_t    s1, s2, cand;
    logic [15:0] cnt;
    logic        same, at_max;

    assign same = s2 == cand;
    assign at_max = cnt == CNT_MAX;
    // A commit repeats every cycle while saturated; only a value change counts as an event.
    assign commit_changed = same && at_max && cand != stable;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= SW_RESET;
            s2 <= SW_RESET;
            cand <= SW_RESET;
            stable <= SW_RESET;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (!same) begin
                cand <= s2;
                cnt <= '0;
            end else if (at_max) begin
                stable <= cand;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end
endmodule

// File: rtl/switch_driver.sv
// switch_driver: debounced DIP-switch register block with change interrupt.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   switch_pin : raw active-low switch pins
//   WE/Addr/Din: bridge write strobe, word select, write data
//   Dout       : read data (Addr=0 switch value, Addr=1 {ien, pending})
//   irq        : level interrupt, pending & ien
module switch_driver
    import switch_driver_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset,
    input  sw_word_t switch_pin,
    input  logic     WE,
    input  logic     Addr,
    input  sw_word_t Din,
    output sw_word_t Dout,
    output logic     irq
);
    sw_word_t stable;
    logic     commit_changed, pending, ien, wr_ctrl, unused_din;

    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk(clk),
        .reset(reset),
        .raw(switch_pin),
        .stable(stable),
        .commit_changed(commit_changed)
    );

    assign wr_ctrl = WE && Addr == SW_CTRL;
    assign unused_din = ^Din[31:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            ien <= 1'b0;
        end else begin
            if (wr_ctrl)
                ien <= Din[IEN];
            // Set beats write-1-to-clear so no change event is lost.
            if (commit_changed)
                pending <= 1'b1;
            else if (wr_ctrl && Din[PENDING])
                pending <= 1'b0;
        end
    end

    assign Dout = Addr == SW_CTRL ? {30'b0, ien, pending} : ~stable;
    assign irq = pending & ien;
endmodule

// File: doc/switch_driver.md
SWITCH_DRIVER -- requirements
Module: switch_driver

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000, number of consecutive equal synchronized samples required before a new switch value is committed; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state advances on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (reset=0 resets, independent of clk).
REQ-004 switch_pin  input  32  raw board DIP-switch pins, active-low, asynchronous to clk.
REQ-005 WE  input  1  write strobe from the bridge, sampled on rising clk.
REQ-006 Addr  input  1  word select: 0 = switch value, 1 = control/status.
REQ-007 Din  input  32  write data.
REQ-008 Dout  output  32  read data, combinational from Addr and internal registers.
REQ-009 irq  output  1  level interrupt request, active-high.

Function
REQ-010 switch_pin SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-011 Debounce: candidate register cand and counter cnt (16 bits); each cycle, if s2 != cand then cand<=s2, cnt<=0; else if cnt == DEBOUNCE_CYCLES-1 then stable<=cand and cnt holds; else cnt<=cnt+1.
REQ-012 Debounce operates on the whole 32-bit word: any bit toggling restarts the count for all bits.
REQ-013 Latency: a pin change held steady is visible in stable at the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples it as edge 1.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES+1 cycles after synchronization SHALL never reach stable.
REQ-015 Addr=0 read: Dout = ~stable (switch closed reads 1).
REQ-016 Addr=1 read: Dout = {30'b0, ien, pending}.
REQ-017 pending SHALL set on the cycle a commit changes stable (cand != stable at commit); a commit with equal value sets nothing.
REQ-018 Write with Addr=1: ien<=Din[1]; if Din[0]=1 pending is cleared (write-1-to-clear); Din[0]=0 leaves pending unchanged.
REQ-019 Simultaneous set and clear of pending: set wins (no lost change event).
REQ-020 Writes with Addr=0 SHALL be ignored with no side effects.
REQ-021 irq = pending & ien, no additional delay.
REQ-022 Counter never wraps: at DEBOUNCE_CYCLES-1 it saturates until cand changes.

Reset
REQ-023 While reset=0: s1, s2, cand, stable = 32'hFFFFFFFF; cnt=0; pending=0; ien=0; hence Dout(Addr=0)=0, irq=0.
REQ-024 Reset asserted mid-debounce SHALL discard the in-progress candidate; after release, a held pin value commits per REQ-013 measured from release.
REQ-025 Reset deassertion is synchronized externally; block needs no internal reset synchronizer.

Structure
REQ-026 Shared package holds: DEBOUNCE_CYCLES default, register offsets (SW_VALUE=0, SW_CTRL=1), status bit positions (PENDING=0, IEN=1), switch reset value 32'hFFFFFFFF.
REQ-027 Synchronizer plus debounce counter SHALL be one sub-module, switch_debouncer (in: clk, reset, raw; out: stable, commit_changed); switch_driver holds registers, read mux, irq.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-028 Reset held, switch_pin=32'h0000_00F0 -> Dout(Addr=0)=0, irq=0; release reset, hold pins -> Dout=32'hFFFF_FF0F at edge 7 after release, pending=1.
REQ-029 From all-released, drive switch_pin[0]=0 for 3 cycles then back to 1 -> Dout(Addr=0) stays 0, pending stays 0.
REQ-030 Write Addr=1 Din=2 (ien=1); hold switch_pin=32'hFFFF_FFFE -> Dout(Addr=0)=1 at edge 7, pending=1, irq=1 same cycle; write Addr=1 Din=3 -> irq=0 next cycle.
REQ-031 Write-1-to-clear on the exact cycle of a new commit -> pending remains 1, irq remains 1.
REQ-032 Write Addr=0 Din=32'h1234_5678 -> Dout(Addr=0) and Dout(Addr=1) unchanged.
REQ-033 Assert reset after 3 stable cycles of a new value, release, hold value -> no commit before edge 7 after release; Dout(Addr=1)=0 during reset.
